// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: constants and types shared by the instruction fetch stage
// and its consumers.
//   RV_NOP            - canonical NOP (addi x0, x0, 0) shown while nothing has been fetched
//   RV_INSTR_BYTES    - bytes per instruction word, also the PC stride
//   FETCH_QUEUE_DEPTH - default fetch-queue depth; decode sizes its skid buffer from it
//   fetch_entry_t     - one fetch-queue entry {pc, instr}
package fetch_unit_pkg;

  localparam logic [31:0] RV_NOP            = 32'h0000_0013;
  localparam int unsigned RV_INSTR_BYTES    = 4;
  localparam int unsigned FETCH_QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_queue.sv
// fetch_queue: synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   push, wdata      - write wdata at the tail this cycle
//   pop              - drop the head this cycle (push and pop may coincide when full)
//   flush            - discard all entries; overrides push and pop
//   rdata            - head entry; holds a stale value while empty
//   count/full/empty - occupancy
// Every storage slot resets to RESET_VAL so the head reads a defined value
// straight out of reset.
module fetch_queue #(
  parameter int unsigned       WIDTH     = 64,
  parameter int unsigned       DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, addresses the
// combinational instruction memory, and queues {pc, instr} for decode.
// Ports:
//   clk, rst_n                - clock, asynchronous active-low reset
//   imem_a / imem_d           - word-aligned fetch address / word returned same cycle
//   redirect_valid/_pc        - new fetch target; flushes the queue, wins over push/pop
//   out_valid/_ready          - handshake to decode
//   out_instr / out_pc        - queue head
//   fetch_fault               - only with FETCH_MISALIGN_TRAP_EN: sticky misaligned-redirect flag
// Build option: FETCH_MISALIGN_TRAP_EN. When undefined, redirect_pc[1:0]
// is ignored and the port fetch_fault does not exist.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = FETCH_QUEUE_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_a,
  input  logic [31:0] imem_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  logic [31:0]  pc_q, pc_d;
  logic         q_push, q_pop;
  logic [CW-1:0] q_count;
  logic         q_full, q_empty;
  fetch_entry_t wr_entry, rd_entry;
  logic         fetch_blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_q, fault_d;
  assign fetch_blocked = fault_q;
  assign fetch_fault   = fault_q;
`else
  logic unused_redirect_lsbs;
  assign fetch_blocked        = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  always_comb begin
    pc_d   = pc_q;
    // A redirect suppresses both sides of the queue in its own cycle so no
    // entry from the abandoned path is consumed or written.
    q_pop  = !q_empty && out_ready && !redirect_valid;
    q_push = !redirect_valid && !fetch_blocked &&
             ((q_count < CW'(QUEUE_DEPTH)) || q_pop);
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_d = fault_q;
`endif
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_d = (redirect_pc[1:0] != 2'b00);
`endif
    end else if (q_push) begin
      pc_d = pc_q + 32'(RV_INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= 1'b0;
`endif
    end else begin
      pc_q <= pc_d;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_q <= fault_d;
`endif
    end
  end

  assign wr_entry = '{pc: pc_q, instr: imem_d};

  fetch_queue #(
    .WIDTH     ($bits(fetch_entry_t)),
    .DEPTH     (QUEUE_DEPTH),
    .RESET_VAL ({RESET_PC, RV_NOP})
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  // Control never writes a full queue unless the head leaves in the same cycle.
  assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full && !q_pop));

  assign imem_a    = pc_q;
  assign out_valid = !q_empty;
  assign out_instr = rd_entry.instr;
  assign out_pc    = rd_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. The reference model is
// the architectural rule "after reset or a redirect to T, decode accepts
// (T, mem[T]), (T+4, mem[T+4]), ... in order"; the stimulus side loads that
// stream into a scoreboard whenever it issues reset or a redirect, and an
// independent monitor pops one entry per observed handshake.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned DEPTH    = 2;
  localparam int unsigned REFILL   = 128;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_a;
  logic [31:0] imem_d;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_fault;
`endif

  fetch_unit #(
    .RESET_PC    (RESET_PC),
    .QUEUE_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_a         (imem_a),
    .imem_d         (imem_d),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_fault    (fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  assign imem_d = mem_word(imem_a);

  int          checks   = 0;
  int          failures = 0;
  int          hs_count = 0;
  logic [63:0] sb_q[$];
  logic        tb_fault = 1'b0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    logic [31:0] a;
    sb_q.delete();
    for (int unsigned i = 0; i < REFILL; i++) begin
      a = start + 32'(i * 4);
      sb_q.push_back({a, mem_word(a)});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
`ifdef FETCH_MISALIGN_TRAP_EN
    if (t[1:0] != 2'b00) begin
      sb_q.delete();
      tb_fault = 1'b1;
    end else begin
      refill(t);
      tb_fault = 1'b0;
    end
`else
    refill({t[31:2], 2'b00});
`endif
    cyc();
    redirect_valid = 1'b0;
  endtask

  // Monitor: consumes one expected entry per handshake and checks that an
  // unaccepted head is held stable.
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc, prev_instr;
  logic [63:0] exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        check("head_hold", {out_valid, out_pc, out_instr}, {1'b1, prev_pc, prev_instr});
      if (out_valid && out_ready && !redirect_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL accept_unexpected actual pc=%0h required=no entry", out_pc);
        end else begin
          exp_e = sb_q.pop_front();
          check("accept", {out_pc, out_instr}, exp_e);
        end
        hs_count++;
      end
`ifdef FETCH_MISALIGN_TRAP_EN
      if (!redirect_valid) check("fault_flag", fetch_fault, tb_fault);
`endif
      prev_hold  = out_valid && !out_ready && !redirect_valid;
      prev_pc    = out_pc;
      prev_instr = out_instr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          h0;
    logic [31:0] t;
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_instr", out_instr, NOP);
    check("rst_pc", out_pc, RESET_PC);
    check("rst_imem_a", imem_a, RESET_PC);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst_fault", fetch_fault, 0);
`endif

    // Reset release: first instruction one cycle later, then 1/cycle.
    refill(RESET_PC);
    rst_n = 1'b1;
    @(negedge clk);
    check("release_valid0", out_valid, 0);
    @(negedge clk);
    check("latency_valid", out_valid, 1);
    check("latency_pc", out_pc, RESET_PC);
    cyc();
    h0 = hs_count;
    repeat (4) cyc();
    check("throughput", 32'(hs_count - h0), 4);

    // Stall: queue fills, pc stops DEPTH words past the head.
    out_ready = 1'b0;
    repeat (5) cyc();
    check("stall_imem_a", imem_a, sb_q[0][63:32] + 32'(4 * DEPTH));
    check("stall_head_pc", out_pc, sb_q[0][63:32]);
    out_ready = 1'b1;
    repeat (4) cyc();

    // Redirect with a full queue: all entries flushed.
    out_ready = 1'b0;
    repeat (3) cyc();
    out_ready = 1'b1;
    redirect_to(32'h0000_0040);
    check("redir_imem_a", imem_a, 32'h40);
    check("redir_valid0", out_valid, 0);
    cyc();
    check("redir_valid1", out_valid, 1);
    check("redir_pc", out_pc, 32'h40);
    repeat (3) cyc();

    // Back-to-back redirects: last wins.
    redirect_to(32'h0000_0020);
    redirect_to(32'h0000_0080);
    check("b2b_imem_a", imem_a, 32'h80);
    repeat (4) cyc();

    // PC wrap.
    redirect_to(32'hFFFF_FFF0);
    h0 = hs_count;
    repeat (8) cyc();
    check("wrap_accepts", 32'(hs_count - h0), 7);

    // Misaligned redirect.
    redirect_to(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (3) begin
      @(negedge clk);
      check("fault_no_valid", out_valid, 0);
      check("fault_pc_hold", imem_a, 32'h100);
    end
    cyc();
    redirect_to(32'h0000_0100);
`endif
    h0 = hs_count;
    repeat (4) cyc();
    check("aligned_accepts", 32'(hs_count - h0), 3);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) begin
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
        redirect_to(t);
      end else begin
        cyc();
      end
    end
    redirect_to(32'h0000_0200);
    out_ready = 1'b1;
    repeat (3) cyc();

    // Asynchronous reset mid-operation.
    #2;
    rst_n    = 1'b0;
    tb_fault = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_imem_a", imem_a, RESET_PC);
    check("async_pc", out_pc, RESET_PC);
    check("async_instr", out_instr, NOP);
    @(posedge clk);
    #1;
    refill(RESET_PC);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerelease_valid0", out_valid, 0);
    @(negedge clk);
    check("rerelease_valid1", out_valid, 1);
    cyc();
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
